// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline definitions for the instruction/data memory arbiter.
// Holds the arbiter state encoding and the default fetch-starvation limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the IF-stage fetch port and the MEM-stage data port onto one
// single-port memory, with data priority bounded by a fetch-starvation counter.
//
// Handshake: a requester raises *_req with its command fields stable and holds
// them until the matching one-cycle *_ack; the memory side sees mem_req held
// with stable mem_* fields until it answers with a one-cycle mem_ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_ack,
    output logic [31:0]      if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    input  logic [3:0]       d_be,
    output logic             d_ack,
    output logic [31:0]      d_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             stall_if,
    output logic             stall_mem,
    output arb_state_t       state_dbg,
    output logic [CNT_W-1:0] starve_cnt_dbg
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_i, grant_d, done;

    assign stall_if       = if_req & ~if_ack;
    assign stall_mem      = d_req & ~d_ack;
    assign state_dbg      = state;
    assign starve_cnt_dbg = starve_cnt;

    // No grant in an ack cycle: the requester still holds the request it was
    // just acked for, so that cycle must not be mistaken for a new request.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (!if_ack && !d_ack) begin
                    if (d_req && !(if_req && starve_cnt == STARVE_LIM)) begin
                        next_state = D_BUSY;
                        grant_d    = 1'b1;
                    end else if (if_req) begin
                        next_state = I_BUSY;
                        grant_i    = 1'b1;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ready) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            starve_cnt <= '0;
        end else begin
            if_ack <= done && (state == I_BUSY);
            d_ack  <= done && (state == D_BUSY);
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
                if (if_req && starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_i) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                mem_be     <= 4'hF;
                starve_cnt <= '0;
            end
            if (done) begin
                mem_req <= 1'b0;
                if (state == I_BUSY) begin
                    if_rdata <= mem_rdata;
                end else if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder with programmable latency,
// driver tasks for both requesters, and an ack monitor fed by an expected queue.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    arb_state_t  state_dbg;
    logic [2:0]  starve_cnt_dbg;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .state_dbg(state_dbg), .starve_cnt_dbg(starve_cnt_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int if_ack_cnt = 0;
    int d_ack_cnt = 0;
    logic [32:0] exp_q[$];   // {is_fetch, rdata}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] model [logic [31:0]];
    int          mem_lat = 1;
    logic        idle_noise = 1'b0;

    initial begin
        int c;
        logic [31:0] w;
        c = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        model[32'h100] = 32'h00500093;
        model[32'h104] = 32'h00A00113;
        model[32'h108] = 32'h00000013;
        model[32'h200] = 32'h12345678;
        model[32'h204] = 32'h11111111;
        model[32'h208] = 32'h22222222;
        model[32'h20C] = 32'h33333333;
        model[32'h210] = 32'h44444444;
        model[32'h300] = 32'hAAAAAAAA;
        forever begin
            @(posedge clk);
            if (reset && mem_req && mem_ready && mem_we) begin
                w = model.exists(mem_addr) ? model[mem_addr] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                model[mem_addr] = w;
            end
            #1;
            if (mem_req) begin
                c++;
                if (c > mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = model.exists(mem_addr) ? model[mem_addr] : 32'h0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hBAD0BAD0;
                end
            end else begin
                c = 0;
                mem_ready = idle_noise;
                mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    // ---------------- ack monitor / scoreboard ----------------
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                check("ack_overlap", {63'b0, if_ack & d_ack}, 64'd0);
                if (if_ack) if_ack_cnt++;
                if (d_ack) d_ack_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {62'b0, if_ack, d_ack}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", {63'b0, if_ack}, {63'b0, e[32]});
                    check("ack_rdata", {32'b0, if_ack ? if_rdata : d_rdata}, {32'b0, e[31:0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_data(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bit got = 0;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (d_ack) got = 1;
        end
        check("d_ack_timeout", {63'b0, got}, 64'd1);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        bit got = 0;
        int stall_bad = 0;
        if_req = 1'b1; if_addr = addr;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (if_ack) got = 1;
            else if (!stall_if) stall_bad++;
        end
        check("if_ack_timeout", {63'b0, got}, 64'd1);
        check("stall_if_held", 64'(stall_bad), 64'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base_if, base_d, busy, unstable;
        logic [31:0] a0;
        reset = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;

        // reset state
        @(negedge clk);
        check("rst_state", {62'b0, state_dbg}, {62'b0, IDLE});
        check("rst_mem_req", {63'b0, mem_req}, 64'd0);
        check("rst_mem_cmd", {mem_we, mem_be, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'b0, mem_wdata}, 64'd0);
        check("rst_acks", {62'b0, if_ack, d_ack}, 64'd0);
        check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        check("rst_starve", {61'b0, starve_cnt_dbg}, 64'd0);

        // simultaneous requests on the first cycle after release: data first
        exp_q.push_back({1'b0, 32'h12345678});
        exp_q.push_back({1'b1, 32'h00A00113});
        fork
            do_data(1'b0, 32'h200, 32'h0, 4'hF);
            do_fetch(32'h104);
            begin #1; @(negedge clk); reset = 1'b1; end
        join

        // fetch only: ack on cycle 3, stall_if on cycles 0-2
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        exp_q.push_back({1'b1, 32'h00500093});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("fetch_stall_c%0d", k), {63'b0, stall_if}, {63'b0, k < 3});
            check($sformatf("fetch_ack_c%0d", k), {63'b0, if_ack}, {63'b0, k == 3});
        end
        @(posedge clk); #1;
        if_req = 1'b0;

        // store: command fields, d_rdata unchanged on the ack
        exp_q.push_back({1'b0, 32'h12345678});
        fork
            do_data(1'b1, 32'h300, 32'hDEADBEEF, 4'b0011);
            begin
                @(negedge clk); @(negedge clk);
                check("st_mem_req", {63'b0, mem_req}, 64'd1);
                check("st_mem_we", {63'b0, mem_we}, 64'd1);
                check("st_mem_addr", {32'b0, mem_addr}, 64'h300);
                check("st_mem_wdata", {32'b0, mem_wdata}, 64'hDEADBEEF);
                check("st_mem_be", {60'b0, mem_be}, 64'h3);
            end
        join
        exp_q.push_back({1'b0, 32'hAAAABEEF});
        do_data(1'b0, 32'h300, 32'h0, 4'hF);

        // starvation: four data grants, then the fetch, then the last data
        exp_q.push_back({1'b0, 32'h12345678});
        exp_q.push_back({1'b0, 32'h11111111});
        exp_q.push_back({1'b0, 32'h22222222});
        exp_q.push_back({1'b0, 32'h33333333});
        exp_q.push_back({1'b1, 32'h00000013});
        exp_q.push_back({1'b0, 32'h44444444});
        fork
            do_fetch(32'h108);
            begin
                do_data(1'b0, 32'h200, 32'h0, 4'hF);
                do_data(1'b0, 32'h204, 32'h0, 4'hF);
                do_data(1'b0, 32'h208, 32'h0, 4'hF);
                do_data(1'b0, 32'h20C, 32'h0, 4'hF);
                do_data(1'b0, 32'h210, 32'h0, 4'hF);
            end
        join
        check("starve_cleared", {61'b0, starve_cnt_dbg}, 64'd0);

        // mem_ready in IDLE is ignored
        base_if = if_ack_cnt; base_d = d_ack_cnt;
        idle_noise = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_noise_state", {62'b0, state_dbg}, {62'b0, IDLE});
        check("idle_noise_acks", 64'(if_ack_cnt - base_if + d_ack_cnt - base_d), 64'd0);
        idle_noise = 1'b0;
        @(posedge clk); #1;

        // variable latency: ready withheld five cycles
        mem_lat = 5;
        base_d = d_ack_cnt;
        busy = 0; unstable = 0;
        exp_q.push_back({1'b0, 32'h11111111});
        fork
            do_data(1'b0, 32'h204, 32'h0, 4'hF);
            begin
                for (int k = 0; k < 50 && busy == 0; k++) begin
                    @(negedge clk);
                    if (mem_req) begin busy = 1; a0 = mem_addr; end
                end
                for (int k = 0; k < 50 && mem_req; k++) begin
                    @(negedge clk);
                    if (mem_req) begin
                        busy++;
                        if (mem_addr !== a0) unstable++;
                    end
                end
            end
        join
        check("varlat_busy_cycles", 64'(busy), 64'd6);
        check("varlat_addr", {32'b0, a0}, 64'h204);
        check("varlat_unstable", 64'(unstable), 64'd0);
        check("varlat_one_ack", 64'(d_ack_cnt - base_d), 64'd1);

        // reset mid-access
        mem_lat = 20;
        base_d = d_ack_cnt;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h208; d_be = 4'hF;
        repeat (3) @(negedge clk);
        check("mid_state_busy", {62'b0, state_dbg}, {62'b0, D_BUSY});
        #1 reset = 1'b0;
        #1;
        check("mid_rst_mem_req", {63'b0, mem_req}, 64'd0);
        check("mid_rst_state", {62'b0, state_dbg}, {62'b0, IDLE});
        d_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("mid_rst_no_ack", 64'(d_ack_cnt - base_d), 64'd0);
        mem_lat = 1;
        exp_q.push_back({1'b0, 32'h22222222});
        do_data(1'b0, 32'h208, 32'h0, 4'hF);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
